df_spi_master: RTL and testbench
================================

# df_spi_master

Clocked SPI master that drives the port-#xxDF register card's serial configuration link. Each transaction sends one 16-bit frame carrying a 3-bit register select and an 8-bit value (#FADF, #FBDF, #FFDF data, or the direct-wait bit). It simultaneously reads back the card's 16-bit response, which is the #EE header followed by the Z80 data-bus byte captured at frame start. It sits on the host/MCU side of the link, in the system clock domain.

## Interface
- CLK_DIV, 4, SCK half-period in clk cycles (H); legal range ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a frame; accepted only when busy=0.
- reg_sel  in  3  target register: 0=#FADF, 1=#FBDF, 2=#FFDF, 3=direct wait (data bit 0), 4–7 no-op on card.
- wdata  in  8  value to write.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse at frame end.
- rdata  out  8  captured bus byte (response bits 7:0); updated at done.
- hdr_err  out  1  response bits 15:8 ≠ #EE; updated at done.
- sck  out  1  SPI clock; idle high.
- mosi  out  1  SPI data out.
- ss_n  out  1  slave select, active-low.
- miso  in  1  SPI data in.

## Operation
- Frame word F[15:0] = {5'b0, reg_sel, wdata}. It is latched at acceptance; later input changes are ignored.
- States: IDLE → LEAD → SHIFT → TRAIL → GAP → IDLE.
- IDLE: ss_n=1, sck=1, mosi=0. When start=1, latch F, clear the RX shift register, and go to LEAD.
- LEAD: ss_n=0, sck=1, mosi=0 for H cycles.
- SHIFT: sck toggles every H cycles, starting with a fall. There are 17 falls (f1..f17) and 16 rises (r1..r16), and the state ends with sck low after f17.
  - f1 is a dummy edge. The card discards this bit and loads its response on r1; mosi=0 at f1.
  - At r_k (k=1..16), mosi ← F[16−k], so F[15] is valid at f2 and F[0] at f17.
  - At f_k (k=2..17), shift miso into RX, MSB first (16 samples).
- TRAIL: after f17, hold ss_n=0 and sck=0 for H cycles. The card commits the register on the ss_n rise.
- GAP: ss_n=1, sck=0 for H cycles. Then sck=1, rdata←RX[7:0], hdr_err←(RX[15:8]≠#EE), pulse done, and return to IDLE.
- start with busy=1 is ignored; it is not queued.
- start asserted in the same cycle as done is ignored. It is accepted from the next cycle on.
- reg_sel 4–7 still produces a full frame. The card ignores it, but rdata/hdr_err remain valid.

## Timing
- Reset values: sck=1, ss_n=1, mosi=0, busy=0, done=0, rdata=#00, hdr_err=0, state IDLE.
- Let cycle 0 be the cycle in which start is sampled.
  - From cycle 1: ss_n=0, busy=1.
  - Edge f_k occurs at cycle 1+(2k−1)H; edge r_k at cycle 1+2kH.
  - f17 occurs at cycle 1+33H.
  - ss_n=1 at cycle 1+34H.
  - sck=1, done=1, busy=0 at cycle 1+35H.
- Frame length is 35H cycles of ss_n-low-plus-gap. With CLK_DIV=4, done arrives at cycle 141.
- All outputs are registered; there is no combinational path from any input to any output.
- miso is sampled in the same clk edge that drives sck low. It must be stable by then; the card changes miso on the rises.
- Reset mid-frame: on the next edge, ss_n=1, sck=1, mosi=0, busy=0, and no done pulse. rdata/hdr_err return to reset values. The card latches a partial frame; software must rewrite.
- rst dominates start in the same cycle.

## Configuration
- DF_SPI_READBACK_EN defined: miso sampling, rdata and hdr_err are implemented as above.
- Not defined:
  - miso is unused and no RX register is built.
  - rdata is constant #00 and hdr_err is constant 0.
  - Frame timing and MOSI content are unchanged.

## Test plan
- Reset, then CLK_DIV=4, start with reg_sel=0, wdata=#5A, and a card model returning {#EE,#3C}:
  - The model latches #FADF=#5A.
  - done occurs at cycle 141.
  - rdata=#3C, hdr_err=0.
- reg_sel=3, wdata=#01, with a bit-level monitor:
  - The 16 mosi bits at f2..f17 are #0301.
  - mosi=0 at f1.
  - Exactly 17 falls and 16 rises occur while ss_n=0.
- Model returns header #E6 with data #FF → rdata=#FF, hdr_err=1. Next frame with header #EE → hdr_err=0.
- Pulse start at cycles 0, 10 and 140 (busy high) → exactly one frame. A start at the done cycle is ignored; a start at done+1 begins a second frame.
- Assert rst at cycle 60 of a frame → next cycle ss_n=1, sck=1, busy=0, no done pulse. A fresh frame then completes normally.
- CLK_DIV=1, reg_sel=2, wdata=#A5 → done at cycle 36. The model latches #FFDF=#A5. Build without DF_SPI_READBACK_EN → rdata stays #00.

Source files
------------

// File: rtl/df_spi_master.sv
// df_spi_master: SPI master for the port-#xxDF register card configuration link.
// Sends one 16-bit frame {5'b0, reg_sel, wdata} per request, MSB first, with a
// leading dummy falling edge. It optionally captures the card's 16-bit response.
// Optional feature macro: DF_SPI_READBACK_EN enables miso capture, rdata and hdr_err.
module df_spi_master #(
   parameter int unsigned CLK_DIV = 4   // SCK half-period in clk cycles, >= 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] reg_sel,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       hdr_err,
   output logic       sck,
   output logic       mosi,
   output logic       ss_n,
   input  logic       miso
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [5:0]    n_edge, n_edge_nxt;   // SCK edges issued so far, f1 counts as 1
   logic [15:0]   frame, frame_nxt;
   logic          sck_q, sck_nxt;
   logic          mosi_q, mosi_nxt;
   logic          ss_n_q, ss_n_nxt;
   logic          busy_q, busy_nxt;
   logic          done_q, done_nxt;
   logic          tick;

   assign tick = (cnt == CNT_MAX);

`ifdef DF_SPI_READBACK_EN
   logic [15:0] rx, rx_nxt;
   logic [7:0]  rdata_q, rdata_nxt;
   logic        hdr_err_q, hdr_err_nxt;
`endif

   // State and output registers; every output comes straight from a flop
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         n_edge <= '0;
         frame  <= '0;
         sck_q  <= 1'b1;
         mosi_q <= 1'b0;
         ss_n_q <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef DF_SPI_READBACK_EN
         rx        <= '0;
         rdata_q   <= '0;
         hdr_err_q <= 1'b0;
`endif
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         n_edge <= n_edge_nxt;
         frame  <= frame_nxt;
         sck_q  <= sck_nxt;
         mosi_q <= mosi_nxt;
         ss_n_q <= ss_n_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
`ifdef DF_SPI_READBACK_EN
         rx        <= rx_nxt;
         rdata_q   <= rdata_nxt;
         hdr_err_q <= hdr_err_nxt;
`endif
      end
   end

   // Next-state and next-output logic for the frame sequencer
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      n_edge_nxt = n_edge;
      frame_nxt  = frame;
      sck_nxt    = sck_q;
      mosi_nxt   = mosi_q;
      ss_n_nxt   = ss_n_q;
      busy_nxt   = busy_q;
      done_nxt   = 1'b0;
`ifdef DF_SPI_READBACK_EN
      rx_nxt      = rx;
      rdata_nxt   = rdata_q;
      hdr_err_nxt = hdr_err_q;
`endif
      case (state)
         IDLE: begin
            // A start coinciding with done is dropped so back-to-back frames keep their gap
            if (start && !done_q) begin
               state_nxt  = LEAD;
               cnt_nxt    = '0;
               n_edge_nxt = '0;
               frame_nxt  = {5'b0, reg_sel, wdata};
               ss_n_nxt   = 1'b0;
               busy_nxt   = 1'b1;
               mosi_nxt   = 1'b0;
`ifdef DF_SPI_READBACK_EN
               rx_nxt = '0;
`endif
            end
         end
         LEAD: begin
            if (tick) begin
               // f1: dummy fall, mosi stays 0
               state_nxt  = SHIFT;
               cnt_nxt    = '0;
               sck_nxt    = 1'b0;
               n_edge_nxt = 6'd1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         SHIFT: begin
            if (tick) begin
               cnt_nxt    = '0;
               n_edge_nxt = n_edge + 6'd1;
               if (!sck_q) begin
                  // rise: present the next frame bit, the card samples it on the next fall
                  sck_nxt   = 1'b1;
                  mosi_nxt  = frame[15];
                  frame_nxt = {frame[14:0], 1'b0};
               end else begin
                  // fall f2..f17: sample miso in the same edge that lowers sck
                  sck_nxt = 1'b0;
`ifdef DF_SPI_READBACK_EN
                  rx_nxt = {rx[14:0], miso};
`endif
                  if (n_edge == 6'd32) state_nxt = TRAIL;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         TRAIL: begin
            if (tick) begin
               // ss_n rise commits the register on the card
               state_nxt = GAP;
               cnt_nxt   = '0;
               ss_n_nxt  = 1'b1;
               mosi_nxt  = 1'b0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         GAP: begin
            if (tick) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               sck_nxt   = 1'b1;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
`ifdef DF_SPI_READBACK_EN
               rdata_nxt   = rx[7:0];
               hdr_err_nxt = (rx[15:8] != 8'hEE);
`endif
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign sck  = sck_q;
   assign mosi = mosi_q;
   assign ss_n = ss_n_q;
   assign busy = busy_q;
   assign done = done_q;

`ifdef DF_SPI_READBACK_EN
   assign rdata   = rdata_q;
   assign hdr_err = hdr_err_q;
`else
   logic unused_miso;
   assign unused_miso = miso;
   assign rdata   = 8'h00;
   assign hdr_err = 1'b0;
`endif

endmodule

// File: tb/tb_df_spi_master.sv
// Testbench for df_spi_master: a behavioural card model (SPI slave) drives miso
// and decodes mosi. It checks frame timing, content and readback for H=4 and H=1.
module tb_df_spi_master;

`ifdef DF_SPI_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start4 = 1'b0, start1 = 1'b0;
   logic [2:0] reg_sel_i = '0;
   logic [7:0] wdata_i = '0;
   logic       miso = 1'b0;

   logic       busy4, done4, hdr_err4, sck4, mosi4, ss_n4;
   logic [7:0] rdata4;
   logic       busy1, done1, hdr_err1, sck1, mosi1, ss_n1;
   logic [7:0] rdata1;

   always #5 clk = ~clk;

   df_spi_master #(.CLK_DIV(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .reg_sel(reg_sel_i), .wdata(wdata_i),
      .busy(busy4), .done(done4), .rdata(rdata4), .hdr_err(hdr_err4),
      .sck(sck4), .mosi(mosi4), .ss_n(ss_n4), .miso(miso));

   df_spi_master #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .reg_sel(reg_sel_i), .wdata(wdata_i),
      .busy(busy1), .done(done1), .rdata(rdata1), .hdr_err(hdr_err1),
      .sck(sck1), .mosi(mosi1), .ss_n(ss_n1), .miso(miso));

   // Selected DUT view
   int         which = 0;
   logic       cur_busy, cur_done, cur_hdr_err, cur_sck, cur_mosi, cur_ss_n;
   logic [7:0] cur_rdata;
   always_comb begin
      cur_busy = busy4; cur_done = done4; cur_hdr_err = hdr_err4; cur_sck = sck4;
      cur_mosi = mosi4; cur_ss_n = ss_n4; cur_rdata = rdata4;
      if (which == 1) begin
         cur_busy = busy1; cur_done = done1; cur_hdr_err = hdr_err1; cur_sck = sck1;
         cur_mosi = mosi1; cur_ss_n = ss_n1; cur_rdata = rdata1;
      end
   end

   // Card link: the idle master sits at ss_n=1, sck=1, mosi=0, so merge both
   wire card_ss_n = ss_n4 & ss_n1;
   wire card_sck  = sck4 & sck1;
   wire card_mosi = mosi4 | mosi1;

   // Card model: loads response on r1, shifts it out on rises, samples mosi on falls after f1
   logic [15:0] resp = '0;
   logic [15:0] card_rx = '0;
   logic        card_f1_mosi = 1'b0;
   int          card_nf = 0, card_nr = 0, card_frames = 0;
   logic [7:0]  card_reg [4] = '{default: 8'h00};

   always @(negedge card_ss_n) begin
      card_nf = 0; card_nr = 0; card_rx = '0; miso = 1'b0;
      card_frames++;
   end
   always @(negedge card_sck) begin
      if (card_ss_n === 1'b0) begin
         card_nf++;
         if (card_nf == 1) card_f1_mosi = card_mosi;
         else card_rx = {card_rx[14:0], card_mosi};
      end
   end
   always @(posedge card_sck) begin
      if (card_ss_n === 1'b0) begin
         card_nr++;
         if (card_nr <= 16) miso = resp[16 - card_nr];
      end
   end
   always @(posedge card_ss_n) begin
      if (card_nf == 17 && card_rx[10:8] < 3'd4) card_reg[card_rx[1 +: 2] * 0 + card_rx[9:8]] = card_rx[7:0];
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_frame(input int w, input logic [2:0] sel, input logic [7:0] wd,
                            input logic [7:0] hdr, input logic [7:0] dat);
      int   h, n;
      logic got;
      h = (w == 1) ? 1 : 4;
      which = w;
      resp = {hdr, dat};
      @(negedge clk);
      reg_sel_i = sel; wdata_i = wd;
      if (w == 1) start1 = 1'b1; else start4 = 1'b1;
      @(posedge clk);                 // cycle 0 sampling edge
      @(negedge clk);
      start4 = 1'b0; start1 = 1'b0;
      reg_sel_i = 3'($urandom); wdata_i = 8'($urandom);   // must not affect the frame
      n = 1;
      chk("ss_n_cycle1", cur_ss_n, 0);
      chk("busy_cycle1", cur_busy, 1);
      got = 1'b0;
      while (n < 2000) begin
         if (cur_done) begin got = 1'b1; break; end
         @(negedge clk); n++;
      end
      chk("done_seen", got, 1);
      chk("done_cycle", n, 1 + 35 * h);
      chk("busy_at_done", cur_busy, 0);
      chk("sck_at_done", cur_sck, 1);
      chk("ss_n_at_done", cur_ss_n, 1);
      chk("rdata", cur_rdata, RB ? dat : 8'h00);
      chk("hdr_err", cur_hdr_err, RB ? (hdr != 8'hEE) : 1'b0);
      chk("mosi_frame", card_rx, {5'b0, sel, wd});
      chk("mosi_f1", card_f1_mosi, 0);
      chk("n_falls", card_nf, 17);
      chk("n_rises", card_nr, 16);
      if (sel < 3'd4) chk("card_reg", card_reg[sel[1:0]], wd);
      @(negedge clk);
      chk("done_pulse_width", cur_done, 0);
   endtask

   initial begin
      int n, f0;
      logic quiet;
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_sck", sck4, 1);   chk("rst_ss_n", ss_n4, 1);  chk("rst_mosi", mosi4, 0);
      chk("rst_busy", busy4, 0); chk("rst_done", done4, 0);  chk("rst_rdata", rdata4, 0);
      chk("rst_hdr_err", hdr_err4, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // directed frames
      run_frame(0, 3'd0, 8'h5A, 8'hEE, 8'h3C);
      run_frame(0, 3'd3, 8'h01, 8'hEE, 8'h81);
      run_frame(0, 3'd1, 8'hC3, 8'hE6, 8'hFF);
      run_frame(0, 3'd2, 8'h24, 8'hEE, 8'h10);
      run_frame(1, 3'd2, 8'hA5, 8'hEE, 8'h6B);
      run_frame(0, 3'd6, 8'h99, 8'hEE, 8'h42);

      // randomized frames on both dividers
      for (int i = 0; i < 8; i++)
         run_frame((i % 3 == 2) ? 1 : 0, 3'($urandom), 8'($urandom),
                   ($urandom_range(0, 1) == 1) ? 8'hEE : 8'($urandom), 8'($urandom));

      // starts while busy and at done are dropped; done+1 starts a new frame
      which = 0; resp = 16'hEE77; f0 = card_frames;
      @(negedge clk);
      reg_sel_i = 3'd1; wdata_i = 8'h11; start4 = 1'b1; n = 0;
      while (n < 400) begin
         @(negedge clk); n++;
         start4 = (n == 10 || n == 140 || n == 141 || n == 142);
         if (n == 141) begin
            chk("busy_frame_done", done4, 1);
            chk("busy_frame_count", card_frames - f0, 1);
         end
         if (n == 142) begin
            chk("done_start_ignored_ss", ss_n4, 1);
            chk("done_start_ignored_busy", busy4, 0);
         end
         if (n == 143) chk("done1_start_busy", busy4, 1);
         if (done4 && n > 143) break;
      end
      start4 = 1'b0;
      chk("second_frame_done", n, 142 + 141);
      chk("second_frame_count", card_frames - f0, 2);
      chk("second_frame_reg", card_reg[1], 8'h11);

      // reset in mid-frame
      resp = 16'hEE5C; f0 = card_frames;
      @(negedge clk);
      reg_sel_i = 3'd0; wdata_i = 8'h33; start4 = 1'b1; n = 0;
      while (n < 60) begin @(negedge clk); n++; start4 = 1'b0; end
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ss_n", ss_n4, 1);  chk("midrst_sck", sck4, 1);
      chk("midrst_busy", busy4, 0);  chk("midrst_mosi", mosi4, 0);
      chk("midrst_rdata", rdata4, 0); chk("midrst_hdr_err", hdr_err4, 0);
      rst = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done4 || !ss_n4) quiet = 1'b0;
      end
      chk("midrst_no_done", quiet, 1);
      run_frame(0, 3'd0, 8'h77, 8'hEE, 8'hA1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
